// File: rtl/neuron_mac.sv
// neuron_mac: serial multiply-accumulate neuron.
//
// Streams N_IN (input, weight) pairs over a valid/ready handshake. The bias is
// added to the sum of the products. The selected activation (linear or ReLU)
// is then applied, and the result is truncated and saturated to a signed
// OUT_W-bit fixed-point value with OUT_FRAC fractional bits.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   s_valid   input beat valid
//   s_ready   block can accept a beat (IDLE or ACCUM)
//   s_k       input value k_i  (signed, FRAC_W fractional bits)
//   s_w       weight w_i       (signed, FRAC_W fractional bits)
//   bias      bias b, sampled on the first beat of a vector
//   act_mode  0 = linear, 1 = ReLU, sampled on the first beat
//   m_valid   result valid
//   m_ready   downstream accepts the result
//   m_z       neuron output z (signed, OUT_FRAC fractional bits)
//   m_sat     result was clipped by saturation
//   busy      a vector is in progress
module neuron_mac #(
   parameter int DATA_W    = 32,
   parameter int FRAC_W    = 24,
   parameter int N_IN      = 2,
   parameter int OUT_W     = 8,
   parameter int OUT_FRAC  = 4,
   parameter int ACC_GUARD = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_k,
   input  logic [DATA_W-1:0] s_w,
   input  logic [DATA_W-1:0] bias,
   input  logic              act_mode,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [OUT_W-1:0]  m_z,
   output logic              m_sat,
   output logic              busy
);

   localparam int ACC_W = DATA_W + ACC_GUARD;
   localparam int P_W   = 2 * DATA_W;
   localparam int SHIFT = FRAC_W - OUT_FRAC;
   localparam int CNT_W = (N_IN > 1) ? $clog2(N_IN + 1) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_IN - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // Accumulator range expressed at product width, for clamping a term.
   localparam logic signed [P_W-1:0] TERM_MAX = {{(P_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
   localparam logic signed [P_W-1:0] TERM_MIN = {{(P_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

   // Output range expressed at accumulator width.
   localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
   localparam logic [OUT_W-1:0]        Z_MAX = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0]        Z_MIN = {1'b1, {(OUT_W-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2,
      OUT   = 2'd3
   } state_t;

   state_t state, state_nxt;

   // Full-precision product, truncated back to FRAC_W fractional bits
   // (toward -inf), then clamped so one term can never wrap the accumulator.
   function automatic logic signed [ACC_W-1:0] term_sat(
      input logic signed [DATA_W-1:0] k,
      input logic signed [DATA_W-1:0] w
   );
      logic signed [P_W-1:0] ke, we, p, t;
      logic signed [ACC_W-1:0] r;
      ke = {{DATA_W{k[DATA_W-1]}}, k};
      we = {{DATA_W{w[DATA_W-1]}}, w};
      p  = ke * we;
      t  = p >>> FRAC_W;
      if (t > TERM_MAX)
         r = TERM_MAX[ACC_W-1:0];
      else if (t < TERM_MIN)
         r = TERM_MIN[ACC_W-1:0];
      else
         r = t[ACC_W-1:0];
      return r;
   endfunction

   // Rescale to the output format, apply ReLU, then saturate.
   // Returns {sat, z}. ReLU clipping of negatives is not flagged as saturation.
   function automatic logic [OUT_W:0] out_sat(
      input logic signed [ACC_W-1:0] a,
      input logic                    relu
   );
      logic signed [ACC_W-1:0] y;
      logic [OUT_W:0]          r;
      y = a >>> SHIFT;
      if (relu && y[ACC_W-1])
         y = '0;
      if (y > Y_MAX)
         r = {1'b1, Z_MAX};
      else if (y < Y_MIN)
         r = {1'b1, Z_MIN};
      else
         r = {1'b0, y[OUT_W-1:0]};
      return r;
   endfunction

   logic signed [ACC_W-1:0] term_p0;
   logic signed [ACC_W-1:0] bias_ext_p0;
   logic signed [ACC_W-1:0] acc_p1;
   logic [CNT_W-1:0]        cnt_p1;
   logic                    mode_p1;
   logic                    accept;

   assign term_p0     = term_sat($signed(s_k), $signed(s_w));
   assign bias_ext_p0 = {{ACC_GUARD{bias[DATA_W-1]}}, bias};
   assign accept      = s_valid && ((state == IDLE) || (state == ACCUM));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      s_ready   = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            s_ready = 1'b1;
            busy    = 1'b0;
            if (s_valid)
               state_nxt = (N_IN == 1) ? DONE : ACCUM;
         end
         ACCUM: begin
            s_ready = 1'b1;
            if (s_valid && (cnt_p1 == CNT_LAST))
               state_nxt = DONE;
         end
         DONE: begin
            state_nxt = OUT;
         end
         OUT: begin
            if (m_ready)
               state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Stage p0 -> p1: accepted beats fold into the accumulator.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_p1  <= '0;
         cnt_p1  <= '0;
         mode_p1 <= 1'b0;
      end else if (accept) begin
         if (state == IDLE) begin
            acc_p1  <= bias_ext_p0 + term_p0;
            cnt_p1  <= CNT_ONE;
            mode_p1 <= act_mode;
         end else begin
            acc_p1 <= acc_p1 + term_p0;
            cnt_p1 <= cnt_p1 + CNT_ONE;
         end
      end
   end

   // Stage p1 -> p2: activation, rescale and saturation into the output register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_valid <= 1'b0;
         m_z     <= '0;
         m_sat   <= 1'b0;
      end else if (state == DONE) begin
         {m_sat, m_z} <= out_sat(acc_p1, mode_p1);
         m_valid      <= 1'b1;
      end else if ((state == OUT) && m_ready) begin
         m_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: self-checking bench for neuron_mac.
// Directed vectors with known results, then randomized vectors checked
// against an arithmetic reference model.
module tb_neuron_mac;

   localparam int DW   = 32;
   localparam int FW   = 24;
   localparam int N    = 2;
   localparam int OW   = 8;
   localparam int OF   = 4;
   localparam int GRD  = 4;
   localparam int ACCW = DW + GRD;

   logic          clk;
   logic          reset;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_k;
   logic [DW-1:0] s_w;
   logic [DW-1:0] bias;
   logic          act_mode;
   logic          m_valid;
   logic          m_ready;
   logic [OW-1:0] m_z;
   logic          m_sat;
   logic          busy;

   int n_chk;
   int n_err;

   logic [DW-1:0] kv [N];
   logic [DW-1:0] wv [N];

   neuron_mac #(
      .DATA_W(DW), .FRAC_W(FW), .N_IN(N), .OUT_W(OW), .OUT_FRAC(OF), .ACC_GUARD(GRD)
   ) dut (
      .clk(clk), .reset(reset),
      .s_valid(s_valid), .s_ready(s_ready), .s_k(s_k), .s_w(s_w),
      .bias(bias), .act_mode(act_mode),
      .m_valid(m_valid), .m_ready(m_ready), .m_z(m_z), .m_sat(m_sat),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: real-number rules with integer arithmetic; returns {sat, z}.
   function automatic logic [OW:0] model(input logic [DW-1:0] b, input logic md);
      longint acc, p, t, y, tmax, tmin;
      tmax = (longint'(1) <<< (ACCW - 1)) - 1;
      tmin = -(longint'(1) <<< (ACCW - 1));
      acc  = longint'($signed(b));
      for (int i = 0; i < N; i++) begin
         p = longint'($signed(kv[i])) * longint'($signed(wv[i]));
         t = p >>> FW;
         if (t > tmax) t = tmax;
         if (t < tmin) t = tmin;
         acc = acc + t;
      end
      acc = (acc <<< (64 - ACCW)) >>> (64 - ACCW);
      y = acc >>> (FW - OF);
      if (md && y < 0) y = 0;
      if (y > 127) return {1'b1, 8'h7F};
      if (y < -128) return {1'b1, 8'h80};
      return {1'b0, y[7:0]};
   endfunction

   function automatic logic [DW-1:0] rnd_val();
      int v;
      if ($urandom_range(0, 3) == 0)
         return $urandom;
      v = int'($urandom_range(0, 32'h2000_0000)) - 32'h1000_0000;
      return 32'(v);
   endfunction

   // Called just after a negedge with the DUT idle; returns just after the
   // negedge following the result handshake.
   task automatic run_vec(input logic [DW-1:0] b, input logic md, input int gap,
                          input int hold, input logic [OW:0] exp_r);
      for (int i = 0; i < N; i++) begin
         if (i > 0) begin
            for (int g = 0; g < gap; g++) begin
               s_valid = 1'b0;
               s_k = $urandom;
               s_w = $urandom;
               @(posedge clk);
               @(negedge clk);
               chk("gap_busy", 64'(busy), 64'd1);
               chk("gap_mvalid", 64'(m_valid), 64'd0);
            end
         end
         chk("s_ready_beat", 64'(s_ready), 64'd1);
         s_valid  = 1'b1;
         s_k      = kv[i];
         s_w      = wv[i];
         bias     = (i == 0) ? b : $urandom;
         act_mode = (i == 0) ? md : ~md;
         @(posedge clk);
         @(negedge clk);
         s_valid  = 1'b0;
         bias     = $urandom;
         act_mode = 1'($urandom);
      end
      chk("lat_early", 64'(m_valid), 64'd0);
      chk("done_sready", 64'(s_ready), 64'd0);
      @(posedge clk);
      @(negedge clk);
      chk("lat_valid", 64'(m_valid), 64'd1);
      chk("m_z", 64'(m_z), 64'(exp_r[OW-1:0]));
      chk("m_sat", 64'(m_sat), 64'(exp_r[OW]));
      for (int h = 0; h < hold; h++) begin
         m_ready = 1'b0;
         @(posedge clk);
         @(negedge clk);
         chk("hold_valid", 64'(m_valid), 64'd1);
         chk("hold_z", 64'(m_z), 64'(exp_r[OW-1:0]));
         chk("hold_sready", 64'(s_ready), 64'd0);
      end
      m_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      m_ready = 1'b0;
      chk("post_valid", 64'(m_valid), 64'd0);
      chk("post_sready", 64'(s_ready), 64'd1);
      chk("post_busy", 64'(busy), 64'd0);
   endtask

   initial begin
      logic [DW-1:0] b;
      logic          md;
      n_chk    = 0;
      n_err    = 0;
      reset    = 1'b0;
      s_valid  = 1'b0;
      s_k      = '0;
      s_w      = '0;
      bias     = '0;
      act_mode = 1'b0;
      m_ready  = 1'b0;

      #3;
      chk("rst_mvalid", 64'(m_valid), 64'd0);
      chk("rst_mz", 64'(m_z), 64'd0);
      chk("rst_msat", 64'(m_sat), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      #9 reset = 1'b1;
      @(negedge clk);
      chk("rst_sready", 64'(s_ready), 64'd1);

      // Linear, two beats: 8*0.1 + 8*0.4 - 1 = 2.9375 after truncation.
      kv[0] = 32'h0800_0000; wv[0] = 32'h0019_9999;
      kv[1] = 32'h0800_0000; wv[1] = 32'h0066_6666;
      run_vec(32'hFF00_0000, 1'b0, 0, 0, {1'b0, 8'h2F});

      // Second weight set; back-to-back with the previous vector.
      wv[0] = 32'h004C_CCCC; wv[1] = 32'h0080_0000;
      run_vec(32'hFF00_0000, 1'b0, 0, 0, {1'b0, 8'h56});

      // Saturation both ways.
      wv[0] = 32'h0100_0000; wv[1] = 32'h0100_0000;
      run_vec(32'h0, 1'b0, 0, 0, {1'b1, 8'h7F});
      wv[0] = 32'hFF00_0000; wv[1] = 32'hFF00_0000;
      run_vec(32'h0, 1'b0, 0, 0, {1'b1, 8'h80});

      // ReLU clips -7.0 to 0 without flagging saturation; linear keeps it.
      kv[0] = 32'h0100_0000; wv[0] = 32'h0080_0000;
      kv[1] = 32'h0100_0000; wv[1] = 32'h0080_0000;
      run_vec(32'hF800_0000, 1'b1, 0, 0, {1'b0, 8'h00});
      run_vec(32'hF800_0000, 1'b0, 0, 0, {1'b0, 8'h90});

      // Gaps between beats and downstream backpressure.
      kv[0] = 32'h0800_0000; wv[0] = 32'h0019_9999;
      kv[1] = 32'h0800_0000; wv[1] = 32'h0066_6666;
      run_vec(32'hFF00_0000, 1'b0, 3, 4, {1'b0, 8'h2F});

      // Reset between edges after the first beat discards the partial sum.
      s_valid  = 1'b1;
      s_k      = kv[0];
      s_w      = wv[0];
      bias     = 32'hFF00_0000;
      act_mode = 1'b0;
      @(posedge clk);
      #2;
      s_valid = 1'b0;
      reset   = 1'b0;
      #1;
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_mvalid", 64'(m_valid), 64'd0);
      chk("midrst_mz", 64'(m_z), 64'd0);
      chk("midrst_msat", 64'(m_sat), 64'd0);
      @(posedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      chk("midrst_after_valid", 64'(m_valid), 64'd0);
      run_vec(32'hFF00_0000, 1'b0, 0, 0, {1'b0, 8'h2F});

      // Randomized vectors against the reference model.
      for (int v = 0; v < 60; v++) begin
         b  = rnd_val();
         md = 1'($urandom);
         for (int i = 0; i < N; i++) begin
            kv[i] = rnd_val();
            wv[i] = rnd_val();
         end
         run_vec(b, md, $urandom_range(0, 2), $urandom_range(0, 3), model(b, md));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
